i2c_codec_slave: RTL



---
 rtl/i2c_codec_slave_if.sv | 13 +
 rtl/i2c_codec_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_slave_if.sv
// Register-side port of the codec control model: readback, commit strobe and status.
interface i2c_codec_slave_if;
  logic [6:0] iRD_ADDR;
  logic [8:0] oRD_DATA;
  logic       oREG_WE;
  logic [6:0] oREG_ADDR;
  logic [8:0] oREG_DATA;
  logic       oBUSY;
  logic       oADDR_ERR;

  modport slave  (input iRD_ADDR, output oRD_DATA, oREG_WE, oREG_ADDR, oREG_DATA, oBUSY, oADDR_ERR);
  modport master (output iRD_ADDR, input oRD_DATA, oREG_WE, oREG_ADDR, oREG_DATA, oBUSY, oADDR_ERR);
endinterface

// File: rtl/i2c_codec_slave.sv
// Write-only I2C responder modelling the codec control port: 16-bit words
// {reg_addr[6:0], reg_data[8:0]} into a 10 x 9-bit register file.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic din_i,
  output logic filt_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_LEN-1:0]    hist_q;
  logic                   filt_q;

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q <= '1;
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      hist_q <= {hist_q[FILT_LEN-2:0], sync_q[SYNC_STAGES-1]};
      if (&hist_q)       filt_q <= 1'b1;
      else if (~|hist_q) filt_q <= 1'b0;
    end
  end

  assign filt_o = filt_q;
endmodule

module i2c_codec_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic I2C_SCLK,
  inout  wire  I2C_SDAT,
  i2c_codec_slave_if.slave bus
);
  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] ADDR       = 4'd1;
  localparam logic [3:0] ACK_A      = 4'd2;
  localparam logic [3:0] BYTE1      = 4'd3;
  localparam logic [3:0] ACK_1      = 4'd4;
  localparam logic [3:0] BYTE2      = 4'd5;
  localparam logic [3:0] ACK_2      = 4'd6;
  localparam logic [3:0] NACK_EXTRA = 4'd7;
  localparam logic [3:0] IGNORE     = 4'd8;

  localparam logic [9:0][8:0] REG_DEF = {9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
                                         9'h00A, 9'h079, 9'h079, 9'h097, 9'h097};

  // lane 0 = SCL, lane 1 = SDA
  logic [1:0] line_raw, line_filt;
  assign line_raw = {I2C_SDAT, I2C_SCLK};

  for (genvar g = 0; g < 2; g++) begin : g_line
    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_cond (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .din_i (line_raw[g]),
      .filt_o(line_filt[g])
    );
  end

  logic scl, sda, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl      = line_filt[0];
  assign sda      = line_filt[1];
  assign scl_rise = scl & ~scl_prev_q;
  assign scl_fall = ~scl & scl_prev_q;
  assign start_c  = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_c   = scl & scl_prev_q & ~sda_prev_q & sda;

  logic [3:0]      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      sh_q, sh_d, byte1_q, byte1_d, byte_full;
  logic            oe_q, oe_d, we_q, we_d, err_q;
  logic [6:0]      waddr_q, waddr_d;
  logic [8:0]      wdata_q, wdata_d;
  logic [9:0][8:0] regs_q;

  assign byte_full = {sh_q[6:0], sda};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    byte1_d  = byte1_q;
    oe_d     = oe_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (start_c) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, BYTE1, BYTE2: if (scl_rise) begin
          sh_d     = byte_full;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            case (state_q)
              ADDR:    state_d = (byte_full[7:1] == SLAVE_ADDR && !byte_full[0]) ? ACK_A : IGNORE;
              BYTE1:   begin byte1_d = byte_full; state_d = ACK_1; end
              default: state_d = ACK_2;
            endcase
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          // First fall is the end of the 8th bit: start driving; second fall ends the ACK clock.
          if (scl_fall) begin
            if (!oe_q) oe_d = 1'b1;
            else begin
              oe_d     = 1'b0;
              bitcnt_d = '0;
              state_d  = (state_q == ACK_A) ? BYTE1 : (state_q == ACK_1) ? BYTE2 : NACK_EXTRA;
            end
          end else if (scl_rise && oe_q && state_q == ACK_2) begin
            we_d    = 1'b1;
            waddr_d = byte1_q[7:1];
            wdata_d = {byte1_q[0], sh_q};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      sh_q       <= '0;
      byte1_q    <= '0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      regs_q     <= REG_DEF;
    end else begin
      scl_prev_q <= scl;
      sda_prev_q <= sda;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sh_q       <= sh_d;
      byte1_q    <= byte1_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      // Register file updates on the edge that ends the commit pulse.
      if (we_q) begin
        if (waddr_q < 7'd10)       regs_q[waddr_q[3:0]] <= wdata_q;
        else if (waddr_q == 7'd15) regs_q <= REG_DEF;
        else                       err_q <= 1'b1;
      end
    end
  end

  assign I2C_SDAT      = oe_q ? 1'b0 : 1'bz;
  assign bus.oRD_DATA  = (bus.iRD_ADDR < 7'd10) ? regs_q[bus.iRD_ADDR[3:0]] : 9'h000;
  assign bus.oREG_WE   = we_q;
  assign bus.oREG_ADDR = waddr_q;
  assign bus.oREG_DATA = wdata_q;
  assign bus.oBUSY     = (state_q != IDLE);
  assign bus.oADDR_ERR = err_q;
endmodule
